// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision field layout, constants and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int EXP_LEN   = 8;
  localparam int MAN_LEN   = 23;
  localparam int BIAS      = 127;
  localparam int SIGN_POS  = EXP_LEN + MAN_LEN;
  localparam int EXP_LSB   = MAN_LEN;
  localparam int DIV_ITERS = 25;

  localparam logic [EXP_LEN-1:0] EXP_ALL1 = '1;
  localparam logic [31:0]        QNAN     = 32'h7FC0_0000;

  // Flag bit positions within {nv, dz, of, uf}.
  localparam logic [3:0] FLAG_NV = 4'b1000;
  localparam logic [3:0] FLAG_DZ = 4'b0100;
  localparam logic [3:0] FLAG_OF = 4'b0010;
  localparam logic [3:0] FLAG_UF = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division iteration: compare/subtract divisor, emit a quotient bit, shift remainder.
// Latency: combinational.
// Backpressure: none; the caller sequences iterations.
module fdiv_step
  import fpu_pkg::*;
(
  input  logic [MAN_LEN+1:0] rem,
  input  logic [MAN_LEN:0]   mb,
  output logic [MAN_LEN+1:0] next_rem,
  output logic               q_bit
);

  logic [MAN_LEN:0] diff;
  logic [MAN_LEN:0] kept;

  // The remainder after a successful subtract is always below mb, so the
  // difference fits in mantissa width and the top bit can be dropped.
  always_comb begin
    q_bit    = (rem >= {1'b0, mb});
    diff     = rem[MAN_LEN:0] - mb;
    kept     = q_bit ? diff : rem[MAN_LEN:0];
    next_rem = {kept, 1'b0};
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single divider (restoring, truncating, denormals flushed to zero).
// Latency: 1 cycle for special operands, 27 cycles accept-to-out_valid for normal operands.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [3:0]   flags
);

  if (N != 32) begin : g_bad_width
    $error("fdiv_seq: only N=32 is supported");
  end

  state_t               state, state_nxt;
  logic [4:0]           cnt;
  logic                 sign;
  logic [EXP_LEN-1:0]   ea, eb;
  logic [MAN_LEN:0]     mb;
  logic [MAN_LEN+1:0]   rem;
  logic [MAN_LEN+1:0]   q;
  logic [MAN_LEN+1:0]   step_rem;
  logic                 step_q;

  logic                 accept;
  logic                 in_sign;
  logic [EXP_LEN-1:0]   a_exp, b_exp;
  logic [MAN_LEN-1:0]   a_man, b_man;
  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                 spec_hit;
  logic [31:0]          spec_out;
  logic [3:0]           spec_flags;

  logic signed [9:0]    e_base, e_norm;
  logic [MAN_LEN-1:0]   man_norm;
  logic [31:0]          norm_out;
  logic [3:0]           norm_flags;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  assign in_sign = a[SIGN_POS] ^ b[SIGN_POS];
  assign a_exp   = a[EXP_LSB +: EXP_LEN];
  assign b_exp   = b[EXP_LSB +: EXP_LEN];
  assign a_man   = a[MAN_LEN-1:0];
  assign b_man   = b[MAN_LEN-1:0];

  fdiv_step u_step (
    .rem      (rem),
    .mb       (mb),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Classify incoming operands and resolve the special-case result up front.
  always_comb begin
    a_zero     = (a_exp == '0);
    b_zero     = (b_exp == '0);
    a_inf      = (a_exp == EXP_ALL1) && (a_man == '0);
    b_inf      = (b_exp == EXP_ALL1) && (b_man == '0);
    a_nan      = (a_exp == EXP_ALL1) && (a_man != '0);
    b_nan      = (b_exp == EXP_ALL1) && (b_man != '0);
    spec_hit   = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    spec_out   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_out   = QNAN;
      spec_flags = FLAG_NV;
    end else if (a_inf) begin
      spec_out = {in_sign, EXP_ALL1, {MAN_LEN{1'b0}}};
    end else if (b_zero) begin
      spec_out   = {in_sign, EXP_ALL1, {MAN_LEN{1'b0}}};
      spec_flags = FLAG_DZ;
    end else begin
      spec_out = {in_sign, {(EXP_LEN+MAN_LEN){1'b0}}};
    end
  end

  // Normalise the 25-bit quotient and range-check the exponent.
  always_comb begin
    e_base     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS - 1));
    e_norm     = q[MAN_LEN+1] ? (e_base + 10'sd1) : e_base;
    man_norm   = q[MAN_LEN+1] ? q[MAN_LEN:1] : q[MAN_LEN-1:0];
    norm_out   = {sign, e_norm[EXP_LEN-1:0], man_norm};
    norm_flags = '0;
    if (e_norm >= 10'sd255) begin
      norm_out   = {sign, EXP_ALL1, {MAN_LEN{1'b0}}};
      norm_flags = FLAG_OF;
    end else if (e_norm <= 10'sd0) begin
      norm_out   = {sign, {(EXP_LEN+MAN_LEN){1'b0}}};
      norm_flags = FLAG_UF;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid)                   state_nxt = spec_hit ? DONE : DIV;
      DIV:  if (cnt == 5'(DIV_ITERS - 1))   state_nxt = NORM;
      NORM:                                 state_nxt = DONE;
      DONE: if (out_ready)                  state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign <= in_sign;
            ea   <= a_exp;
            eb   <= b_exp;
            mb   <= {1'b1, b_man};
            rem  <= {2'b01, a_man};
            q    <= '0;
            cnt  <= '0;
            if (spec_hit) begin
              out       <= spec_out;
              flags     <= spec_flags;
              out_valid <= 1'b1;
            end
          end
        end
        DIV: begin
          rem <= step_rem;
          q   <= {q[MAN_LEN:0], step_q};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          out       <= norm_out;
          flags     <= norm_flags;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 Parameter N, default 32, operand/result width. Only 32 (1/8/23 layout) SHALL be supported; any other value SHALL fail elaboration.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 in_valid  in  1  operands a, b valid.
REQ-005 in_ready  out  1  block can accept operands.
REQ-006 a  in  N  dividend, IEEE-754 single.
REQ-007 b  in  N  divisor, IEEE-754 single.
REQ-008 out_valid  out  1  result valid.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out  out  N  quotient a/b.
REQ-011 flags  out  4  {nv, dz, of, uf}: invalid, divide-by-zero, overflow, underflow.

Function
REQ-012 States SHALL be IDLE, DIV, NORM and DONE; in_ready = (state==IDLE).
REQ-013 Accept = in_valid & in_ready. On accept, the block SHALL latch the sign (a[31]^b[31]), both exponents, and both mantissas with the hidden 1 (ma, mb, 24 bits each).
REQ-014 Classification at accept: exponent 0 is treated as zero (denormals flushed); exponent 255 with mantissa 0 is inf; exponent 255 with mantissa not 0 is NaN.
REQ-015 Special cases go IDLE->DONE in one cycle (out_valid the cycle after accept), as follows:
- any NaN, 0/0, or inf/inf -> 0x7FC00000, nv=1
- finite-nonzero/0 -> signed inf, dz=1
- 0/x or x/inf -> signed zero
- inf/x -> signed inf
REQ-016 Normal operands go IDLE->DIV and compute q = floor((ma<<24)/mb), 25 bits, by restoring division.
REQ-017 DIV produces one quotient bit per cycle, MSB first, for exactly 25 cycles under a 5-bit iteration counter. It then moves to NORM.
REQ-018 NORM (1 cycle) SHALL use e = ea - eb + 126 computed in 10-bit signed arithmetic.
- If q[24]=1: mantissa = q[23:1], e = e + 1.
- Otherwise: mantissa = q[22:0].
- Rounding is truncation.
REQ-019 Exponent range in NORM:
- e >= 255 -> signed inf with of=1.
- e <= 0 -> signed zero with uf=1.
- Otherwise out = {sign, e[7:0], mantissa}.
REQ-020 Latency from accept to out_valid for normal operands SHALL be exactly 27 cycles.
REQ-021 In DONE, out_valid=1 and out and flags SHALL stay stable until out_valid & out_ready.
REQ-022 On that handshake the block SHALL return to IDLE; the next accept is no earlier than the following cycle (no bypass).
REQ-023 out and flags SHALL be registered and hold their last value while not in DONE; in_valid is ignored outside IDLE.
REQ-024 Only one operation is outstanding at a time; a and b may change after accept without affecting the result.

Reset
REQ-025 With rst=1 at a clock edge: state<=IDLE, counter<=0, out<=0, flags<=0, out_valid<=0. in_ready is therefore 1 in the cycle after reset.
REQ-026 Reset mid-operation (DIV, NORM or DONE) SHALL abandon the operation with no result produced.
REQ-027 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-028 Package fpu_pkg SHALL hold:
- the field widths and positions (EXP_LEN=8, MAN_LEN=23, BIAS=127);
- the canonical NaN constant;
- the state enum type.
REQ-029 Sub-module fdiv_step SHALL implement one combinational restoring iteration: {rem, mb} -> {next_rem, q_bit}. fdiv_seq instantiates it once.

Verification
REQ-030 a=0x40C00000, b=0x40000000 (6/2) -> out=0x40400000, flags=0, out_valid exactly 27 cycles after accept.
REQ-031 a=0x3F800000, b=0x40400000 (1/3) -> out=0x3EAAAAAA (truncated), flags=0.
REQ-032 Special cases, each with out_valid 1 cycle after accept:
- a=0x3F800000, b=0x00000000 -> 0x7F800000, dz=1.
- a=0, b=0 -> 0x7FC00000, nv=1.
REQ-033 a=0x7F000000, b=0x3E800000 -> 0x7F800000, of=1. a=0x00800000, b=0x7F000000 -> 0x00000000, uf=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out and flags stable, in_ready=0. Pulse rst in cycle 12 of DIV -> in_ready=1 next cycle and no out_valid. Back-to-back accepts -> results in order.
